hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage PCPU; sits beside the forwarding unit.
- Resolves the hazards forwarding cannot cover: load-use (1 bubble), multi-cycle mul/div occupancy (N-cycle stall) and taken-branch/jump redirect (flush).
- Drives PC/IF-ID write enables and stage-register flushes.
- Keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl_sat_counter.sv | 28 ++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg : shared encodings and load-use helper for hazard_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam logic [1:0] HC_IDLE    = 2'd0;
  localparam logic [1:0] HC_MD_BUSY = 2'd1;
  localparam logic [1:0] HC_MD_REL  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load into $0 is architecturally a no-op, so it can never feed ID.
  function automatic logic load_use_hit(
    input logic       memrd,
    input logic [4:0] rw,
    input logic [4:0] ra,
    input logic [4:0] rb,
    input logic       use_a,
    input logic       use_b
  );
    return memrd && (rw != REG_ZERO) &&
           ((use_a && (rw == ra)) || (use_b && (rw == rb)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_if : pipeline hazard inputs and sequencing/counter outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_Ra;
  logic [4:0]       id_Rb;
  logic             id_useRa;
  logic             id_useRb;
  logic             id_md;
  logic [4:0]       ex_Rw;
  logic             ex_MemRd;
  logic             mem_redirect;
  logic             pc_wr;
  logic             ifid_wr;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_Ra, id_Rb, id_useRa, id_useRb, id_md, ex_Rw, ex_MemRd, mem_redirect,
    input  pc_wr, ifid_wr, ifid_flush, idex_flush, exmem_flush, md_busy,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_Ra, id_Rb, id_useRa, id_useRb, id_md, ex_Rw, ex_MemRd, mem_redirect,
    output pc_wr, ifid_wr, ifid_flush, idex_flush, exmem_flush, md_busy,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : event counter that sticks at all-ones instead of wrapping
// Revision: 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : load-use bubble, mul/div occupancy stall and redirect flush
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  // Counter holds the number of MD_BUSY cycles still to run (MD_LAT-2 total).
  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
  localparam logic [1:0] MD_ENTRY = (MD_LAT == 2) ? HC_MD_REL : HC_MD_BUSY;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          load_use;
  logic          pc_wr, ifid_wr, ifid_flush, idex_flush, exmem_flush, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign load_use = load_use_hit(bus.ex_MemRd, bus.ex_Rw, bus.id_Ra, bus.id_Rb,
                                 bus.id_useRa, bus.id_useRb);

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_wr       = 1'b1;
    ifid_wr     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = (state_q == HC_MD_BUSY) || (state_q == HC_MD_REL);

    if (bus.mem_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = HC_IDLE;
      md_cnt_d    = '0;
    end else begin
      case (state_q)
        HC_MD_BUSY: begin
          pc_wr      = 1'b0;
          ifid_wr    = 1'b0;
          idex_flush = 1'b1;
          md_cnt_d   = md_cnt_q - CW'(1);
          if (md_cnt_q == CW'(1)) begin
            state_d = HC_MD_REL;
          end
        end
        HC_MD_REL: begin
          state_d = HC_IDLE;
        end
        default: begin
          // A pending load completes under the md stall, so md wins.
          if (bus.id_md) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
            state_d    = MD_ENTRY;
            md_cnt_d   = CW'(MD_LAT - 2);
          end else if (load_use) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end

    if (!rst_n) begin
      pc_wr       = 1'b1;
      ifid_wr     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      md_busy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HC_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_wr),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.mem_redirect),
    .q     (flush_cnt)
  );

  assign bus.pc_wr       = pc_wr;
  assign bus.ifid_wr     = ifid_wr;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.md_busy     = md_busy;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed vector table plus mul/div, redirect, reset sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) if_m ();
  hazard_ctrl_if #(.CNT_W(3))  if_s ();

  hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m)
  );

  // Narrow-counter twin sees identical stimulus; used for saturation.
  hazard_ctrl #(.MD_LAT(4), .CNT_W(3)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  assign if_s.id_Ra        = if_m.id_Ra;
  assign if_s.id_Rb        = if_m.id_Rb;
  assign if_s.id_useRa     = if_m.id_useRa;
  assign if_s.id_useRb     = if_m.id_useRb;
  assign if_s.id_md        = if_m.id_md;
  assign if_s.ex_Rw        = if_m.ex_Rw;
  assign if_s.ex_MemRd     = if_m.ex_MemRd;
  assign if_s.mem_redirect = if_m.mem_redirect;

  typedef struct {
    logic [4:0] ra;
    logic [4:0] rb;
    logic       use_a;
    logic       use_b;
    logic [4:0] rw;
    logic       memrd;
    logic       redir;
    logic [4:0] exp;   // {pc_wr, ifid_wr, ifid_flush, idex_flush, exmem_flush}
  } vec_t;

  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_REDIR = 5'b11111;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  vec_t vec [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {if_m.pc_wr, if_m.ifid_wr, if_m.ifid_flush, if_m.idex_flush, if_m.exmem_flush};
  endfunction

  task automatic clear_inputs();
    if_m.id_Ra = 5'd0; if_m.id_Rb = 5'd0; if_m.id_useRa = 1'b0; if_m.id_useRb = 1'b0;
    if_m.id_md = 1'b0; if_m.ex_Rw = 5'd0; if_m.ex_MemRd = 1'b0; if_m.mem_redirect = 1'b0;
  endtask

  task automatic set_load_use();
    if_m.ex_MemRd = 1'b1; if_m.ex_Rw = 5'd5; if_m.id_Ra = 5'd5; if_m.id_useRa = 1'b1;
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_stall_cnt"}, 32'(if_m.stall_cnt), exp_stall);
    chk({nm, "_flush_cnt"}, 32'(if_m.flush_cnt), exp_flush);
  endtask

  // id_md held through the release cycle; optional coincident load-use.
  task automatic run_md(input string nm, input bit with_lu);
    if_m.id_md = 1'b1;
    if (with_lu) set_load_use();
    @(negedge clk);
    chk({nm, "_c0_out"}, 32'(outs()), 32'(O_STALL));
    chk({nm, "_c0_busy"}, 32'(if_m.md_busy), 32'd0);
    tick();
    if_m.ex_MemRd = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d_out", nm, c), 32'(outs()), 32'(O_STALL));
      chk($sformatf("%s_c%0d_busy", nm, c), 32'(if_m.md_busy), 32'd1);
      tick();
    end
    @(negedge clk);
    chk({nm, "_rel_out"}, 32'(outs()), 32'(O_NORM));
    chk({nm, "_rel_busy"}, 32'(if_m.md_busy), 32'd1);
    tick();
    clear_inputs();
    @(negedge clk);
    chk({nm, "_idle_out"}, 32'(outs()), 32'(O_NORM));
    chk({nm, "_idle_busy"}, 32'(if_m.md_busy), 32'd0);
    exp_stall += 3;
    chk_cnts(nm);
  endtask

  initial begin
    vec[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_NORM};
    vec[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, O_STALL};
    vec[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, O_NORM};
    vec[3] = '{5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, O_NORM};
    vec[4] = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, O_STALL};
    vec[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, O_NORM};
    vec[6] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, O_REDIR};
    vec[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_REDIR};
    vec[8] = '{5'd6, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, O_NORM};
    vec[9] = '{5'd9, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, O_STALL};

    clear_inputs();
    rst_n = 1'b0;
    if_m.id_md = 1'b1;
    set_load_use();
    tick();
    @(negedge clk);
    chk("rst_out", 32'(outs()), 32'(O_NORM));
    chk("rst_busy", 32'(if_m.md_busy), 32'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnts("rst");
    tick();

    for (int i = 0; i < 10; i++) begin
      if_m.id_Ra = vec[i].ra; if_m.id_Rb = vec[i].rb;
      if_m.id_useRa = vec[i].use_a; if_m.id_useRb = vec[i].use_b;
      if_m.ex_Rw = vec[i].rw; if_m.ex_MemRd = vec[i].memrd;
      if_m.mem_redirect = vec[i].redir; if_m.id_md = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), 32'(outs()), 32'(vec[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(if_m.md_busy), 32'd0);
      if (!vec[i].exp[4]) exp_stall++;
      if (vec[i].redir) exp_flush++;
      tick();
      chk_cnts($sformatf("vec%0d", i));
    end
    clear_inputs();
    tick();

    run_md("md", 1'b0);
    tick();
    run_md("md_lu", 1'b1);
    tick();

    // Redirect lands in the second MD_BUSY cycle and aborts the sequence.
    if_m.id_md = 1'b1;
    tick();
    tick();
    if_m.mem_redirect = 1'b1;
    @(negedge clk);
    chk("abort_out", 32'(outs()), 32'(O_REDIR));
    tick();
    clear_inputs();
    @(negedge clk);
    chk("abort_next_out", 32'(outs()), 32'(O_NORM));
    chk("abort_next_busy", 32'(if_m.md_busy), 32'd0);
    exp_stall += 2;
    exp_flush += 1;
    chk_cnts("abort");
    tick();

    // Reset asserted in MD_BUSY.
    if_m.id_md = 1'b1;
    tick();
    rst_n = 1'b0;
    if_m.id_md = 1'b0;
    @(negedge clk);
    chk("rstmd_out", 32'(outs()), 32'(O_NORM));
    chk("rstmd_busy", 32'(if_m.md_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    chk("rstmd_next_out", 32'(outs()), 32'(O_NORM));
    chk("rstmd_next_busy", 32'(if_m.md_busy), 32'd0);
    chk_cnts("rstmd");
    chk("rstmd_sat_stall", 32'(if_s.stall_cnt), 32'd0);
    tick();

    set_load_use();
    for (int c = 0; c < 10; c++) tick();
    clear_inputs();
    exp_stall += 10;
    @(negedge clk);
    chk_cnts("sat");
    chk("sat_stall_cnt3", 32'(if_s.stall_cnt), 32'd7);
    tick();
    @(negedge clk);
    chk("sat_hold_cnt3", 32'(if_s.stall_cnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
